// File: rtl/isa_pkg.sv
// Shared ISA definitions: opcodes, instruction-class predicates, immediate sizes and encoder states.
package isa_pkg;

  localparam logic [3:0] OP_ADD    = 4'h0;
  localparam logic [3:0] OP_SUB    = 4'h1;
  localparam logic [3:0] OP_XOR    = 4'h2;
  localparam logic [3:0] OP_RED    = 4'h3;
  localparam logic [3:0] OP_SLL    = 4'h4;
  localparam logic [3:0] OP_SRA    = 4'h5;
  localparam logic [3:0] OP_ROR    = 4'h6;
  localparam logic [3:0] OP_PADDSB = 4'h7;
  localparam logic [3:0] OP_LW     = 4'h8;
  localparam logic [3:0] OP_SW     = 4'h9;
  localparam logic [3:0] OP_LHB    = 4'hA;
  localparam logic [3:0] OP_LLB    = 4'hB;
  localparam logic [3:0] OP_B      = 4'hC;
  localparam logic [3:0] OP_BR     = 4'hD;
  localparam logic [3:0] OP_PCS    = 4'hE;
  localparam logic [3:0] OP_HLT    = 4'hF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCEPT = 2'd1,
    WRITE  = 2'd2,
    DONE   = 2'd3
  } enc_state_e;

  typedef enum logic [1:0] {
    IMM_NONE = 2'd0,
    IMM_4    = 2'd1,
    IMM_8    = 2'd2,
    IMM_9    = 2'd3
  } imm_sz_e;

  typedef struct packed {
    logic [3:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] c;
    logic [8:0] imm;
  } fields_t;

  function automatic logic is_rrr(input logic [3:0] op);
    return !op[3] || (op == OP_LW) || (op == OP_SW);
  endfunction

  function automatic logic is_imm8(input logic [3:0] op);
    return (op == OP_LHB) || (op == OP_LLB);
  endfunction

  function automatic logic is_b(input logic [3:0] op);
    return op == OP_B;
  endfunction

  function automatic logic is_br(input logic [3:0] op);
    return op == OP_BR;
  endfunction

  function automatic logic is_pcs(input logic [3:0] op);
    return op == OP_PCS;
  endfunction

  function automatic logic is_hlt(input logic [3:0] op);
    return op == OP_HLT;
  endfunction

  function automatic imm_sz_e imm_size(input logic [3:0] op);
    imm_sz_e sz;
    case (op)
      OP_SLL, OP_SRA, OP_ROR, OP_LW, OP_SW: sz = IMM_4;
      OP_LHB, OP_LLB:                        sz = IMM_8;
      OP_B:                                  sz = IMM_9;
      default:                               sz = IMM_NONE;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational fields->16-bit word packer with the field-range error flag; no state, zero latency.
module instr_pack
  import isa_pkg::*;
(
  input  fields_t     fields_i,
  output logic [15:0] word_o,
  output logic        range_err_o
);

  always_comb begin
    word_o = {fields_i.op, 12'h000};
    if (is_rrr(fields_i.op)) begin
      word_o = {fields_i.op, fields_i.a, fields_i.b, fields_i.c};
    end else if (is_imm8(fields_i.op)) begin
      word_o = {fields_i.op, fields_i.a, fields_i.imm[7:0]};
    end else if (is_b(fields_i.op)) begin
      word_o = {fields_i.op, fields_i.a[3:1], fields_i.imm};
    end else if (is_br(fields_i.op)) begin
      word_o = {fields_i.op, fields_i.a[3:1], 1'b0, fields_i.b, 4'h0};
    end else if (is_pcs(fields_i.op)) begin
      word_o = {fields_i.op, fields_i.a, 8'h00};
    end
  end

  // Only 8-bit immediates can be out of range; unused fields are never checked.
  assign range_err_o = (imm_size(fields_i.op) == IMM_8) && fields_i.imm[8];

endmodule

// File: rtl/instr_encoder.sv
// Packs field bundles into ISA words and writes them to imem; mem_we rises one cycle after acceptance
// and holds until mem_ready. Optional macro INSTR_ENCODER_CHECKSUM_EN adds the csum output.
module instr_encoder
  import isa_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int ADDR_STEP = 2,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [3:0]        in_a,
  input  logic [3:0]        in_b,
  input  logic [3:0]        in_c,
  input  logic [8:0]        in_imm,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              done,
  output logic              full,
  output logic              err,
  output logic [ADDR_W-1:0] count
`ifdef INSTR_ENCODER_CHECKSUM_EN
  ,
  output logic [15:0]       csum
`endif
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   STEP = (ADDR_W+1)'(ADDR_STEP);

  enc_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic [15:0]       word_q, word_d;
  logic              err_q, err_d;
  logic              full_q, full_d;
`ifdef INSTR_ENCODER_CHECKSUM_EN
  logic [15:0]       csum_q, csum_d;
`endif

  fields_t           fields;
  logic [15:0]       pack_word;
  logic              pack_err;
  logic [ADDR_W:0]   addr_next;
  logic              addr_ovf;
  logic              word_is_hlt;
  logic              accept;
  logic              wr_fire;

  assign fields = '{op: in_op, a: in_a, b: in_b, c: in_c, imm: in_imm};

  instr_pack u_pack (
    .fields_i    (fields),
    .word_o      (pack_word),
    .range_err_o (pack_err)
  );

  // One extra bit catches the carry out of the address counter.
  assign addr_next   = {1'b0, addr_q} + STEP;
  assign addr_ovf    = addr_next[ADDR_W];
  assign word_is_hlt = is_hlt(word_q[15:12]);
  assign accept      = (state_q == ACCEPT) && in_valid && !start;
  assign wr_fire     = (state_q == WRITE) && mem_ready && !start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = ACCEPT;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        ACCEPT:  if (in_valid && !pack_err) state_d = WRITE;
        WRITE:   if (mem_ready) state_d = (word_is_hlt || addr_ovf) ? DONE : ACCEPT;
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  // start gates both handshakes so a same-cycle restart never leaks a bundle or a write.
  always_comb begin
    in_ready = (state_q == ACCEPT) && !start;
    mem_we   = (state_q == WRITE) && !start;
    done     = (state_q == DONE);
  end

  always_comb begin
    addr_d  = addr_q;
    count_d = count_q;
    word_d  = word_q;
    err_d   = err_q;
    full_d  = full_q;
`ifdef INSTR_ENCODER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    if (start) begin
      addr_d  = BASE;
      count_d = '0;
      err_d   = 1'b0;
      full_d  = 1'b0;
`ifdef INSTR_ENCODER_CHECKSUM_EN
      csum_d  = '0;
`endif
    end else begin
      if (accept) begin
        if (pack_err) begin
          err_d = 1'b1;
        end else begin
          word_d = pack_word;
        end
      end
      if (wr_fire) begin
        count_d = count_q + ADDR_W'(1);
`ifdef INSTR_ENCODER_CHECKSUM_EN
        csum_d  = csum_q ^ word_q;
`endif
        if (!word_is_hlt) begin
          if (addr_ovf) begin
            full_d = 1'b1;
          end else begin
            addr_d = addr_next[ADDR_W-1:0];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= BASE;
      count_q <= '0;
      word_q  <= '0;
      err_q   <= 1'b0;
      full_q  <= 1'b0;
`ifdef INSTR_ENCODER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      addr_q  <= addr_d;
      count_q <= count_d;
      word_q  <= word_d;
      err_q   <= err_d;
      full_q  <= full_d;
`ifdef INSTR_ENCODER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = word_q;
  assign err       = err_q;
  assign full      = full_q;
  assign count     = count_q;
`ifdef INSTR_ENCODER_CHECKSUM_EN
  assign csum      = csum_q;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: a 16-bit-address instance with randomized traffic and a
// 4-bit-address instance for address-space exhaustion.
module tb_instr_encoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, in_valid, in_ready, mem_we, mem_ready, done, full, err;
  logic [3:0]  in_op, in_a, in_b, in_c;
  logic [8:0]  in_imm;
  logic [15:0] mem_addr, mem_wdata, count;

  logic        s_start, s_in_valid, s_in_ready, s_mem_we, s_mem_ready, s_done, s_full, s_err;
  logic [3:0]  s_in_op, s_in_a, s_in_b, s_in_c;
  logic [8:0]  s_in_imm;
  logic [3:0]  s_mem_addr, s_count;
  logic [15:0] s_mem_wdata;

  instr_encoder #(.ADDR_W(16), .ADDR_STEP(2), .BASE_ADDR(0)) u_dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_imm(in_imm),
    .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .done(done), .full(full), .err(err), .count(count)
  );

  instr_encoder #(.ADDR_W(4), .ADDR_STEP(2), .BASE_ADDR(0)) u_small (
    .clk(clk), .rst(rst), .start(s_start), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_op(s_in_op), .in_a(s_in_a), .in_b(s_in_b), .in_c(s_in_c), .in_imm(s_in_imm),
    .mem_we(s_mem_we), .mem_ready(s_mem_ready), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
    .done(s_done), .full(s_full), .err(s_err), .count(s_count)
  );

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   m_addr, m_count;
  bit   m_err, m_done;
  bit   rdy_hold = 1'b1;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Reference encoding written as field-weighted sums straight from the ISA layout.
  function automatic logic [15:0] model_word(int op, int a, int b, int c, int imm);
    int w;
    if (op <= 9)                  w = op * 4096 + a * 256 + b * 16 + c;
    else if (op == 10 || op == 11) w = op * 4096 + a * 256 + imm % 256;
    else if (op == 12)            w = op * 4096 + (a / 2) * 512 + imm;
    else if (op == 13)            w = op * 4096 + (a / 2) * 512 + b * 16;
    else if (op == 14)            w = op * 4096 + a * 256;
    else                          w = op * 4096;
    return w[15:0];
  endfunction

  function automatic bit model_bad(int op, int imm);
    return (op == 10 || op == 11) && imm >= 256;
  endfunction

  // Monitor: every accepted write must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && mem_we && mem_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected", mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", {16'h0, mem_addr}, {16'h0, e.addr});
        check("wr_data", {16'h0, mem_wdata}, {16'h0, e.data});
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rdy_hold) mem_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic set_rdy(input bit hold, input bit val);
    @(posedge clk);
    #1;
    rdy_hold  = hold;
    mem_ready = val;
  endtask

  task automatic model_restart();
    exp_q.delete();
    m_addr = 0; m_count = 0; m_err = 0; m_done = 0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    model_restart();
  endtask

  task automatic send(input int op, input int a, input int b, input int c, input int imm);
    int   cyc;
    bit   bad;
    exp_t e;
    @(posedge clk); #1;
    in_op = 4'(op); in_a = 4'(a); in_b = 4'(b); in_c = 4'(c); in_imm = 9'(imm);
    in_valid = 1'b1;
    cyc = 0;
    @(negedge clk);
    while (!in_ready && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    if (!in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: in_ready=0 for 200 cycles, op %0d", op);
      @(posedge clk); #1; in_valid = 1'b0;
      return;
    end
    bad = model_bad(op, imm);
    if (!bad) begin
      e.addr = m_addr[15:0];
      e.data = model_word(op, a, b, c, imm);
      exp_q.push_back(e);
      m_count++;
      if (op == 15) m_done = 1;
      else if (m_addr + 2 < 65536) m_addr += 2;
    end
    @(posedge clk); #1; in_valid = 1'b0;
    @(negedge clk);
    if (bad) begin
      m_err = 1;
      check("rej_we", {31'h0, mem_we}, 0);
      check("rej_in_ready", {31'h0, in_ready}, 1);
      check("rej_err", {31'h0, err}, 1);
    end else begin
      check("latency_we", {31'h0, mem_we}, 1);
    end
  endtask

  task automatic drain();
    int cyc;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    check("drain_pending", exp_q.size(), 0);
    @(negedge clk);
  endtask

  task automatic s_send(input int op, input int a, input int b, input int c, input int exp_addr);
    int cyc;
    @(posedge clk); #1;
    s_in_op = 4'(op); s_in_a = 4'(a); s_in_b = 4'(b); s_in_c = 4'(c); s_in_imm = 9'h0;
    s_in_valid = 1'b1;
    cyc = 0;
    @(negedge clk);
    while (!s_in_ready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    if (!s_in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL s_send_timeout: small in_ready=0, op %0d", op);
    end
    @(posedge clk); #1; s_in_valid = 1'b0;
    @(negedge clk);
    check("s_we", {31'h0, s_mem_we}, 1);
    check("s_addr", {28'h0, s_mem_addr}, exp_addr);
    check("s_data", {16'h0, s_mem_wdata}, {16'h0, model_word(op, a, b, c, 0)});
  endtask

  initial begin
    int cnt_before;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0;
    in_op = '0; in_a = '0; in_b = '0; in_c = '0; in_imm = '0;
    mem_ready = 1'b0;
    s_start = 1'b0; s_in_valid = 1'b0; s_mem_ready = 1'b1;
    s_in_op = '0; s_in_a = '0; s_in_b = '0; s_in_c = '0; s_in_imm = '0;
    model_restart();

    #12;
    check("rst_in_ready", {31'h0, in_ready}, 0);
    check("rst_mem_we", {31'h0, mem_we}, 0);
    check("rst_addr", {16'h0, mem_addr}, 0);
    check("rst_wdata", {16'h0, mem_wdata}, 0);
    check("rst_done", {31'h0, done}, 0);
    check("rst_full", {31'h0, full}, 0);
    check("rst_err", {31'h0, err}, 0);
    check("rst_count", {16'h0, count}, 0);
    @(negedge clk); #2; rst = 1'b0;

    // IDLE ignores bundles until start
    @(posedge clk); #1; in_valid = 1'b1;
    @(negedge clk); check("idle_in_ready", {31'h0, in_ready}, 0);
    @(posedge clk); #1; in_valid = 1'b0;
    @(negedge clk); check("idle_mem_we", {31'h0, mem_we}, 0);

    set_rdy(1, 1);
    pulse_start();
    send(0, 1, 2, 3, 0);
    drain();
    check("add_count", {16'h0, count}, 1);
    check("add_next_addr", {16'h0, mem_addr}, 2);
    send(10, 4, 0, 0, 'h0AB);
    send(12, 4, 0, 0, 'h1F0);
    send(13, 14, 5, 0, 0);
    drain();

    // memory stalls for three cycles
    set_rdy(1, 0);
    send(14, 3, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      check("stall_we", {31'h0, mem_we}, 1);
      check("stall_in_ready", {31'h0, in_ready}, 0);
      if (exp_q.size() > 0) begin
        check("stall_addr", {16'h0, mem_addr}, {16'h0, exp_q[0].addr});
        check("stall_data", {16'h0, mem_wdata}, {16'h0, exp_q[0].data});
      end
      if (k < 2) @(negedge clk);
    end
    @(posedge clk); #1; mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("stall_single_we", {31'h0, mem_we}, 0);
    check("stall_count", {16'h0, count}, m_count);

    // range error: rejected, then next bundle lands at the unchanged address
    send(11, 2, 0, 0, 'h1FF);
    send(1, 7, 8, 9, 0);
    drain();
    check("err_sticky", {31'h0, err}, 1);
    check("err_count", {16'h0, count}, m_count);

    set_rdy(0, 0);
    for (int i = 0; i < 60; i++) begin
      send($urandom_range(0, 14), $urandom_range(0, 15), $urandom_range(0, 15),
           $urandom_range(0, 15), $urandom_range(0, 511));
    end
    drain();
    set_rdy(1, 1);
    drain();
    check("rand_count", {16'h0, count}, m_count);
    check("rand_err", {31'h0, err}, {31'h0, m_err});
    check("rand_addr", {16'h0, mem_addr}, m_addr);

    // HLT terminates; further bundles are ignored
    send(15, 5, 6, 7, 'h55);
    drain();
    check("hlt_done", {31'h0, done}, {31'h0, m_done});
    check("hlt_in_ready", {31'h0, in_ready}, 0);
    check("hlt_full", {31'h0, full}, 0);
    cnt_before = m_count;
    @(posedge clk); #1; in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("hlt_ignore_ready", {31'h0, in_ready}, 0);
      check("hlt_ignore_we", {31'h0, mem_we}, 0);
    end
    @(posedge clk); #1; in_valid = 1'b0;
    @(negedge clk);
    check("hlt_count_hold", {16'h0, count}, cnt_before);

    pulse_start();
    @(negedge clk);
    check("restart_done", {31'h0, done}, 0);
    check("restart_err", {31'h0, err}, 0);
    check("restart_count", {16'h0, count}, 0);
    check("restart_addr", {16'h0, mem_addr}, 0);
    send(2, 3, 4, 5, 0);
    drain();

    // start beats a same-cycle bundle
    @(posedge clk); #1; in_valid = 1'b1; in_op = 4'h0; start = 1'b1;
    @(negedge clk);
    check("startprio_in_ready", {31'h0, in_ready}, 0);
    @(posedge clk); #1; in_valid = 1'b0; start = 1'b0;
    model_restart();
    @(negedge clk);
    check("startprio_no_we", {31'h0, mem_we}, 0);
    check("startprio_count", {16'h0, count}, 0);

    // start drops a pending write
    set_rdy(1, 0);
    send(3, 1, 1, 1, 0);
    pulse_start();
    @(negedge clk);
    check("drop_we", {31'h0, mem_we}, 0);
    check("drop_in_ready", {31'h0, in_ready}, 1);
    set_rdy(1, 1);
    send(4, 6, 6, 6, 0);
    drain();
    check("drop_next_addr", {16'h0, mem_addr}, 2);
    check("drop_count", {16'h0, count}, 1);

    // asynchronous reset mid-write
    set_rdy(1, 0);
    send(5, 2, 2, 2, 0);
    @(negedge clk); #2; rst = 1'b1;
    #1;
    check("arst_we", {31'h0, mem_we}, 0);
    check("arst_in_ready", {31'h0, in_ready}, 0);
    check("arst_addr", {16'h0, mem_addr}, 0);
    model_restart();
    @(negedge clk); #2; rst = 1'b0;

    // 4-bit address space: eight words exhaust it
    @(posedge clk); #1; s_start = 1'b1;
    @(posedge clk); #1; s_start = 1'b0;
    for (int i = 0; i < 8; i++) s_send(i, i, i + 1, 15 - i, i * 2);
    @(negedge clk);
    check("s_full", {31'h0, s_full}, 1);
    check("s_done", {31'h0, s_done}, 1);
    check("s_count", {28'h0, s_count}, 8);
    check("s_in_ready", {31'h0, s_in_ready}, 0);
    @(posedge clk); #1; s_start = 1'b1;
    @(posedge clk); #1; s_start = 1'b0;
    @(negedge clk);
    check("s_restart_full", {31'h0, s_full}, 0);
    check("s_restart_done", {31'h0, s_done}, 0);
    check("s_restart_count", {28'h0, s_count}, 0);
    s_send(9, 1, 2, 3, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
